// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the packed-BCD to binary converter.
//   DIGIT_W    : width of one BCD digit
//   BCD_MAX    : largest legal digit value
//   state_t    : converter FSM states (IDLE, SHIFT, DONE)
//   cnt_width  : width needed for an iteration counter that reaches bin_w
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter wide enough to hold the values 0..bin_w.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational per-digit correction used by reverse double-dabble.
// After a right shift a digit that reads 8 or more has received a carry of
// ten's weight from the digit above (which in binary is worth 8); subtracting
// 3 turns that 8 back into the 5 it represents in decimal.
//   din  : shifted BCD digit
//   dout : din >= 8 ? din - 3 : din   (4-bit, no borrow out)
// -----------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// -----------------------------------------------------------------------------
// bcd_to_binary
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble):
// each SHIFT cycle shifts {bcd_reg, bin_reg} right by one and corrects every
// BCD digit that reads 8 or more by subtracting 3. After BIN_W iterations the
// binary value sits in bin_reg. One conversion in flight at a time.
//
// Parameters
//   DIGITS : number of BCD digits on bcd_in
//   BIN_W  : binary result width, 2**BIN_W > 10**DIGITS - 1
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   conversion request, only sampled in IDLE
//   bcd_in  in   packed digits, digit 0 in [3:0]; captured on accepted start
//   bcd_neg in   (BCD_TO_BINARY_SIGN_EN only) negate the result
//   busy    out  high while iterating
//   done    out  one-cycle pulse, bin_out/err valid from this cycle
//   err     out  high with done when a captured nibble exceeded 9
//   bin_out out  result, held until the next done; BIN_W bits unsigned, or
//                BIN_W+1 bits two's complement with BCD_TO_BINARY_SIGN_EN
//
// Configuration macro: BCD_TO_BINARY_SIGN_EN
// -----------------------------------------------------------------------------
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 9,
  parameter int BIN_W  = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
`ifdef BCD_TO_BINARY_SIGN_EN
  input  logic                     bcd_neg,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     err,
`ifdef BCD_TO_BINARY_SIGN_EN
  output logic [BIN_W:0]           bin_out
`else
  output logic [BIN_W-1:0]         bin_out
`endif
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int CNT_W = cnt_width(BIN_W);

  state_t             state;
  state_t             state_next;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt;
`ifdef BCD_TO_BINARY_SIGN_EN
  logic               neg_reg;
`endif

  // ---------------------------------------------------------------------------
  // Input validation: any nibble above 9 makes the whole word illegal.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] nibble_bad;
  logic              in_bad;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
      assign nibble_bad[gi] = (bcd_in[gi*DIGIT_W +: DIGIT_W] > BCD_MAX);
    end
  endgenerate

  assign in_bad = |nibble_bad;

  // ---------------------------------------------------------------------------
  // One iteration of the datapath: shift right, then correct every digit.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_shift;

  assign bcd_shift = bcd_reg >> 1;
  assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adj (
        .din  (bcd_shift[gi*DIGIT_W +: DIGIT_W]),
        .dout (bcd_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  // Final result as it will be registered on the edge entering DONE.
`ifdef BCD_TO_BINARY_SIGN_EN
  logic [BIN_W:0] result;
  // Negating zero gives zero, so -0 needs no special case.
  assign result = neg_reg ? (-{1'b0, bin_shift}) : {1'b0, bin_shift};
`else
  logic [BIN_W-1:0] result;
  assign result = bin_shift;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------------
  // State, datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      bin_out <= '0;
`ifdef BCD_TO_BINARY_SIGN_EN
      neg_reg <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD_TO_BINARY_SIGN_EN
            neg_reg <= bcd_neg;
`endif
            // An illegal word skips straight to DONE, so its visible outputs
            // are written here; a legal word gets err cleared together with
            // its result so that err and bin_out only ever move entering DONE.
            if (in_bad) begin
              err     <= 1'b1;
              bin_out <= '0;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_shift;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) begin
            bin_out <= result;
            err     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

  localparam int DIGITS = 9;
  localparam int BIN_W  = 30;
  localparam int BCD_W  = DIGITS * 4;
`ifdef BCD_TO_BINARY_SIGN_EN
  localparam int OUT_W  = BIN_W + 1;
`else
  localparam int OUT_W  = BIN_W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [BCD_W-1:0] bcd_in = '0;
  logic             bcd_neg = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [OUT_W-1:0] bin_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
`ifdef BCD_TO_BINARY_SIGN_EN
    .bcd_neg (bcd_neg),
`endif
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits, optional negation, wrapped to OUT_W.
  function automatic void ref_conv(input logic [BCD_W-1:0] b, input logic neg,
                                   output logic [OUT_W-1:0] val, output logic e);
    longint v = 0;
    longint p = 1;
    int d;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) e = 1'b1;
      v = v + longint'(d) * p;
      p = p * 10;
    end
    if (e) val = '0;
    else begin
      if (neg) v = -v;
      val = OUT_W'(v);
    end
  endfunction

  logic neg_eff;
`ifdef BCD_TO_BINARY_SIGN_EN
  assign neg_eff = bcd_neg;
`else
  assign neg_eff = 1'b0;
`endif

  // Behavioural timeline model: cycles remaining until done after acceptance.
  int               m_left = 0;
  bit               m_done = 0;
  logic [OUT_W-1:0] m_bin = '0;
  logic             m_err = 1'b0;
  logic [OUT_W-1:0] m_pend = '0;
  logic             m_pend_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_bin = '0; m_err = 1'b0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1; m_bin = m_pend; m_err = 1'b0;
      end
    end else if (start) begin
      ref_conv(bcd_in, neg_eff, m_pend, m_pend_err);
      if (m_pend_err) begin
        m_done = 1; m_bin = '0; m_err = 1'b1;
      end else begin
        m_left = BIN_W;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_busy", busy, (m_left > 0) ? 1 : 0);
    chk("cyc_done", done, m_done ? 1 : 0);
    chk("cyc_bin_out", bin_out, m_bin);
    if (m_done) chk("cyc_err", err, m_err);
  end

  task automatic run_conv(input string name, input logic [BCD_W-1:0] b, input logic neg,
                          input longint unsigned exp_val, input logic exp_err);
    int k;
    int busy_cnt;
    @(negedge clk);
    bcd_in = b; bcd_neg = neg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, (k < 100) ? 1 : 0, 1);
    chk({name, "_latency"}, k, exp_err ? 0 : BIN_W);
    chk({name, "_busy_cycles"}, busy_cnt, exp_err ? 0 : BIN_W);
    chk({name, "_bin_out"}, bin_out, exp_val);
    chk({name, "_err"}, err, exp_err);
    $display("conv %s bcd=0x%09h neg=%0d -> bin_out=0x%0h err=%0d latency=%0d", name, b, neg, bin_out, err, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] rv;
    logic re;
    int dones;
    logic [OUT_W-1:0] got;

    // Pin the reference model with hand-computed values.
    ref_conv(36'h000000255, 1'b0, rv, re);
    chk("model_255", rv, 255);
    ref_conv(36'h999999999, 1'b0, rv, re);
    chk("model_max", rv, 64'h3B9AC9FF);
    ref_conv(36'h00000A001, 1'b0, rv, re);
    chk("model_bad_err", re, 1);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bin_out", bin_out, 0);
    rst_n = 1'b1;

    run_conv("dec255", 36'h000000255, 1'b0, 255, 1'b0);
    run_conv("zero", 36'h000000000, 1'b0, 0, 1'b0);
    run_conv("max", 36'h999999999, 1'b0, 64'h3B9AC9FF, 1'b0);
    run_conv("bad_digit", 36'h00000A001, 1'b0, 0, 1'b1);
    run_conv("after_bad", 36'h000000007, 1'b0, 7, 1'b0);
`ifdef BCD_TO_BINARY_SIGN_EN
    run_conv("neg255", 36'h000000255, 1'b1, 64'h7FFFFF01, 1'b0);
    run_conv("neg_zero", 36'h000000000, 1'b1, 0, 1'b0);
`endif

    // A start pulse mid-conversion must be ignored.
    @(negedge clk);
    bcd_in = 36'h000000255; bcd_neg = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; got = '0;
    for (int k = 0; k < BIN_W + 8; k++) begin
      if (done) begin dones++; got = bin_out; end
      if (k == 5) begin bcd_in = 36'h999999999; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    chk("ignored_start_dones", dones, 1);
    chk("ignored_start_bin_out", got, 255);
    $display("conv ignored_start -> bin_out=0x%0h dones=%0d", got, dones);

    // Reset asserted in the middle of SHIFT.
    run_conv("pre_reset", 36'h999999999, 1'b0, 64'h3B9AC9FF, 1'b0);
    @(negedge clk);
    bcd_in = 36'h000000255; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_bin_out", bin_out, 0);
    $display("reset mid-conversion -> busy=%0d done=%0d err=%0d bin_out=0x%0h", busy, done, err, bin_out);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv("post_reset", 36'h000000123, 1'b0, 123, 1'b0);

    // Randomized traffic; the per-cycle compare checks it against the model.
    for (int n = 0; n < 40; n++) begin
      logic [BCD_W-1:0] b;
      int hold;
      for (int i = 0; i < DIGITS; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) b[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
      ref_conv(b, 1'b0, rv, re);
      @(negedge clk);
      bcd_in = b; bcd_neg = 1'($urandom_range(0, 1)); start = 1'b1;
      hold = ($urandom_range(0, 9) == 0) ? 80 : 1;
      repeat (hold) @(negedge clk);
      start = 1'b0;
      repeat (BIN_W + 2 + $urandom_range(0, 3)) @(negedge clk);
      $display("rand %0d bcd=0x%09h neg=%0d hold=%0d -> bin_out=0x%0h err=%0d", n, b, bcd_neg, hold, bin_out, err);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
